// File: rtl/fifo_thresh.sv
// First-word-fall-through FIFO with wrap-bit pointers, registered occupancy,
// almost-full/almost-empty thresholds and a sticky underflow flag.
module fifo_thresh #(
  parameter int WIDTH_P     = 8,
  parameter int PTR_WIDTH_P = 4,
  parameter int AFULL_P     = (1 << PTR_WIDTH_P) - 2,
  parameter int AEMPTY_P    = 2
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   flush_i,
  input  logic                   valid_i,
  input  logic [WIDTH_P-1:0]     data_i,
  output logic                   ready_o,
  output logic                   valid_o,
  output logic [WIDTH_P-1:0]     data_o,
  input  logic                   yumi_i,
  output logic [PTR_WIDTH_P:0]   count_o,
  output logic                   almost_full_o,
  output logic                   almost_empty_o,
  output logic                   err_o
);

  localparam int CAP_P = 1 << PTR_WIDTH_P;
  localparam logic [PTR_WIDTH_P:0] ptr_one_lp = (PTR_WIDTH_P+1)'(1);
  localparam logic [PTR_WIDTH_P:0] afull_lp   = (PTR_WIDTH_P+1)'(AFULL_P);
  localparam logic [PTR_WIDTH_P:0] aempty_lp  = (PTR_WIDTH_P+1)'(AEMPTY_P);

  if (PTR_WIDTH_P < 1) begin : g_bad_ptr_width
    $error("fifo_thresh: PTR_WIDTH_P must be >= 1");
  end
  if (AEMPTY_P < 0 || AEMPTY_P >= AFULL_P || AFULL_P > CAP_P) begin : g_bad_thresh
    $error("fifo_thresh: thresholds must satisfy 0 <= AEMPTY_P < AFULL_P <= CAP_P");
  end

  logic [WIDTH_P-1:0]   mem [CAP_P];
  logic [PTR_WIDTH_P:0] rd_ptr;
  logic [PTR_WIDTH_P:0] wr_ptr;
  logic [PTR_WIDTH_P:0] count;
  logic                 err;
  logic                 full;
  logic                 empty;
  logic                 enq;
  logic                 deq;

  // Wrap bit distinguishes full from empty when the address bits match.
  assign empty = (rd_ptr == wr_ptr);
  assign full  = (rd_ptr[PTR_WIDTH_P-1:0] == wr_ptr[PTR_WIDTH_P-1:0]) &&
                 (rd_ptr[PTR_WIDTH_P] != wr_ptr[PTR_WIDTH_P]);
  assign enq   = valid_i & ~full;
  assign deq   = yumi_i & ~empty;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + ptr_one_lp;
      if (deq) rd_ptr <= rd_ptr + ptr_one_lp;
      unique case ({enq, deq})
        2'b10:   count <= count + ptr_one_lp;
        2'b01:   count <= count - ptr_one_lp;
        default: count <= count;
      endcase
    end
  end

  // Underflow is sticky through flush; only reset clears it.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      err <= 1'b0;
    end else if (yumi_i && empty) begin
      err <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq && !flush_i) begin
      mem[wr_ptr[PTR_WIDTH_P-1:0]] <= data_i;
    end
  end

  assign ready_o        = ~full;
  assign valid_o        = ~empty;
  assign data_o         = mem[rd_ptr[PTR_WIDTH_P-1:0]];
  assign count_o        = count;
  assign almost_full_o  = (count >= afull_lp);
  assign almost_empty_o = (count <= aempty_lp);
  assign err_o          = err;

endmodule
